// File: rtl/alu_result_display_pkg.sv
// Shared constants for the ALU result display: active-low 7-segment glyphs,
// blanking pattern and flag bit positions.
package alu_disp_pkg;

    localparam int RESULT_W = 16;
    localparam int FLAG_W   = 5;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Segment order {g,f,e,d,c,b,a}, a lit segment is driven low.
    localparam logic [6:0] SEG_HEX [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam int FLG_C = 4;
    localparam int FLG_L = 3;
    localparam int FLG_F = 2;
    localparam int FLG_Z = 1;
    localparam int FLG_N = 0;

    // True when digit idx and every more significant digit are zero; digit 0 is never blank.
    function automatic logic digit_blank(input logic [RESULT_W-1:0] value, input logic [1:0] idx);
        logic [RESULT_W-1:0] upper;
        upper = value >> {idx, 2'b00};
        return (idx != 2'd0) && (upper == '0);
    endfunction

endpackage

// File: rtl/alu_result_display_if.sv
// ALU-to-display bundle: captured result/flags in, board-facing seg/anode/LED pins out.
interface alu_result_display_if;
    import alu_disp_pkg::*;

    logic [RESULT_W-1:0] result;
    logic [FLAG_W-1:0]   flags;
    logic                capture;
    logic                freeze;
    logic [6:0]          seg;
    logic [3:0]          an;
    logic                dp;
    logic [FLAG_W-1:0]   led;

    modport master (
        output result, flags, capture, freeze,
        input  seg, an, dp, led
    );

    modport slave (
        input  result, flags, capture, freeze,
        output seg, an, dp, led
    );

endinterface

// File: rtl/alu_result_display_hex_to_seg7.sv
// Combinational nibble to active-low 7-segment glyph lookup.
module hex_to_seg7
    import alu_disp_pkg::*;
(
    input  logic [3:0] i_nibble,
    output logic [6:0] o_seg
);

    assign o_seg = SEG_HEX[i_nibble];

endmodule

// File: rtl/alu_result_display.sv
// Captures the ALU result/flags and scans the result as four hex digits on a multiplexed display.
// Define ALU_DISP_LZB_EN to blank leading zero digits (digit 0 always shown).
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
)
(
    input  logic                 clk,
    input  logic                 rst_n,
    alu_result_display_if.slave  disp
);

    localparam int DIV_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_idx;
    logic [RESULT_W-1:0] r_value;
    logic [FLAG_W-1:0]   r_flags;
    logic [6:0]          r_seg;
    logic [3:0]          r_an;

    logic                w_tick;
    logic                w_capture;
    logic [3:0]          w_nibble;
    logic [6:0]          w_glyph;
    logic                w_blank;
    logic [6:0]          w_seg_next;
    logic [3:0]          w_an_next;

    assign w_tick    = (r_div == DIV_LAST);
    assign w_capture = disp.capture & ~disp.freeze;
    assign w_nibble  = r_value[{r_idx, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .i_nibble (w_nibble),
        .o_seg    (w_glyph)
    );

    always_comb begin
        w_blank = 1'b0;
`ifdef ALU_DISP_LZB_EN
        w_blank = digit_blank(r_value, r_idx);
`endif
        w_seg_next = w_blank ? SEG_BLANK : w_glyph;
        w_an_next  = w_blank ? 4'hF : ~(4'b0001 << r_idx);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
            r_idx <= 2'd0;
        end else if (w_tick) begin
            r_div <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_div <= r_div + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value <= '0;
            r_flags <= '0;
        end else if (w_capture) begin
            r_value <= disp.result;
            r_flags <= disp.flags;
        end
    end

    // seg and an load together from the current index/value so a slot never mixes two digits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            r_seg <= w_seg_next;
            r_an  <= w_an_next;
        end
    end

    assign disp.seg = r_seg;
    assign disp.an  = r_an;
    assign disp.dp  = 1'b1;
    assign disp.led = r_flags;

endmodule

// File: tb/tb_alu_result_display.sv
// Self-checking bench for alu_result_display: cycle scoreboard plus vector table and corner sequences.
module tb_alu_result_display;

    localparam int REFRESH_DIV = 4;

    typedef struct packed {
        logic [6:0] seg;
        logic [3:0] an;
        logic       dp;
        logic [4:0] led;
    } outRec_t;

    typedef struct {
        logic [15:0] result;
        logic [4:0]  flags;
        logic [6:0]  glyph [4];
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_result_display_if dispIf ();

    alu_result_display #(.REFRESH_DIV(REFRESH_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .disp  (dispIf)
    );

    always #5 clk = ~clk;

    outRec_t     expQ [$];
    int          checks = 0;
    int          errors = 0;
    logic [15:0] mValue;
    logic [4:0]  mFlags;
    int          mIdx;
    int          mDiv;
    int          shownIdx;

    function automatic logic [6:0] glyphOf(input logic [3:0] n);
        case (n)
            4'h0: return 7'h40;  4'h1: return 7'h79;  4'h2: return 7'h24;  4'h3: return 7'h30;
            4'h4: return 7'h19;  4'h5: return 7'h12;  4'h6: return 7'h02;  4'h7: return 7'h78;
            4'h8: return 7'h00;  4'h9: return 7'h10;  4'hA: return 7'h08;  4'hB: return 7'h03;
            4'hC: return 7'h46;  4'hD: return 7'h21;  4'hE: return 7'h06;  default: return 7'h0E;
        endcase
    endfunction

    function automatic logic isBlank(input logic [15:0] v, input int k);
`ifdef ALU_DISP_LZB_EN
        logic [15:0] up;
        up = v >> (4 * k);
        return (k != 0) && (up == 16'h0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] res, input logic [4:0] flg,
                                 input logic cap, input logic frz);
        dispIf.result  = res;
        dispIf.flags   = flg;
        dispIf.capture = cap;
        dispIf.freeze  = frz;
    endtask

    task automatic resetModel();
        mValue = 16'h0;
        mFlags = 5'h0;
        mIdx = 0;
        mDiv = 0;
        expQ.delete();
    endtask

    // Expected outputs after the coming edge come from the state held before it.
    task automatic predictEdge();
        outRec_t e;
        logic [3:0] nib;
        logic cap;
        nib = 4'(mValue >> (4 * mIdx));
        cap = dispIf.capture && !dispIf.freeze;
        e.seg = isBlank(mValue, mIdx) ? 7'h7F : glyphOf(nib);
        e.an  = isBlank(mValue, mIdx) ? 4'hF : ~(4'(1) << mIdx);
        e.dp  = 1'b1;
        e.led = cap ? dispIf.flags : mFlags;
        expQ.push_back(e);
        shownIdx = mIdx;
        if (cap) begin
            mValue = dispIf.result;
            mFlags = dispIf.flags;
        end
        if (mDiv == REFRESH_DIV - 1) begin
            mDiv = 0;
            mIdx = (mIdx + 1) % 4;
        end else begin
            mDiv++;
        end
    endtask

    task automatic checkOutput(input string name);
        outRec_t e;
        outRec_t a;
        if (expQ.size() == 0) begin
            check({name, "_empty_queue"}, 32'd0, 32'd1);
        end else begin
            e = expQ.pop_front();
            a = {dispIf.seg, dispIf.an, dispIf.dp, dispIf.led};
            check(name, 32'(a), 32'(e));
        end
    endtask

    task automatic stepCycle(input string name);
        predictEdge();
        @(posedge clk);
        #1;
        checkOutput(name);
    endtask

    vec_t vecs [6];

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{16'h8300, 5'b00001, '{7'h40, 7'h40, 7'h30, 7'h00}};
        vecs[1] = '{16'h1234, 5'b10100, '{7'h19, 7'h30, 7'h24, 7'h79}};
        vecs[2] = '{16'hABCD, 5'b11111, '{7'h21, 7'h46, 7'h03, 7'h08}};
`ifdef ALU_DISP_LZB_EN
        vecs[3] = '{16'h0001, 5'b00010, '{7'h79, 7'h7F, 7'h7F, 7'h7F}};
        vecs[4] = '{16'h0000, 5'b00000, '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
        vecs[5] = '{16'h00F0, 5'b01000, '{7'h40, 7'h0E, 7'h7F, 7'h7F}};
`else
        vecs[3] = '{16'h0001, 5'b00010, '{7'h79, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h0000, 5'b00000, '{7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[5] = '{16'h00F0, 5'b01000, '{7'h40, 7'h0E, 7'h40, 7'h40}};
`endif

        applyStimulus(16'h0, 5'h0, 1'b0, 1'b0);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 32'({dispIf.seg, dispIf.an, dispIf.dp, dispIf.led}),
              32'({7'h7F, 4'hF, 1'b1, 5'h0}));

        rst_n = 1'b1;
        resetModel();
        stepCycle("first_edge");
        check("first_edge_an", 32'(dispIf.an), 32'(4'b1110));

        // Table vectors: capture one cycle, change the input so the latch is proven, then scan.
        for (int v = 0; v < 6; v++) begin
            applyStimulus(vecs[v].result, vecs[v].flags, 1'b1, 1'b0);
            stepCycle("vec_capture");
            check("vec_led", 32'(dispIf.led), 32'(vecs[v].flags));
            applyStimulus(~vecs[v].result, ~vecs[v].flags, 1'b0, 1'b0);
            stepCycle("vec_settle");
            for (int c = 0; c < 16; c++) begin
                stepCycle("vec_scan");
                if (vecs[v].glyph[shownIdx] == 7'h7F)
                    check("vec_slot_blank", 32'({dispIf.an, dispIf.seg}), 32'({4'hF, 7'h7F}));
                else
                    check("vec_slot_digit", 32'({dispIf.an, dispIf.seg}),
                          32'({~(4'(1) << shownIdx), vecs[v].glyph[shownIdx]}));
            end
        end

        // Reset asserted mid-scan acts without a clock edge.
        applyStimulus(16'h8300, 5'b00001, 1'b1, 1'b0);
        stepCycle("pre_reset_capture");
        stepCycle("pre_reset_scan");
        rst_n = 1'b0;
        #1;
        check("midscan_reset", 32'({dispIf.seg, dispIf.an, dispIf.dp, dispIf.led}),
              32'({7'h7F, 4'hF, 1'b1, 5'h0}));
        applyStimulus(16'h8300, 5'b00001, 1'b0, 1'b0);
        rst_n = 1'b1;
        resetModel();
        stepCycle("reset_release");
        check("release_an_seg", 32'({dispIf.an, dispIf.seg}), 32'({4'b1110, 7'h40}));

        // Freeze overrides a held capture, then releasing it captures immediately.
        applyStimulus(16'h8300, 5'b00001, 1'b1, 1'b0);
        stepCycle("freeze_setup");
        applyStimulus(16'h7FFF, 5'b11110, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) stepCycle("frozen");
        check("frozen_led", 32'(dispIf.led), 32'(5'b00001));
        applyStimulus(16'h7FFF, 5'b11110, 1'b1, 1'b0);
        stepCycle("unfreeze_capture");
        check("unfreeze_led", 32'(dispIf.led), 32'(5'b11110));
        applyStimulus(16'h0, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) stepCycle("unfrozen_scan");

        // Capture on the same edge as the digit-3 to digit-0 tick.
        begin
            int guard;
            guard = 0;
            while (!(mIdx == 3 && mDiv == REFRESH_DIV - 1) && guard < 32) begin
                stepCycle("align");
                guard++;
            end
            if (guard >= 32) check("align_timeout", 32'd0, 32'd1);
        end
        applyStimulus(16'hFFFF, 5'b10101, 1'b1, 1'b0);
        stepCycle("tick_capture");
        applyStimulus(16'h0, 5'h0, 1'b0, 1'b0);
        stepCycle("tick_show");
        check("tick_digit0_F", 32'({dispIf.an, dispIf.seg}), 32'({4'b1110, 7'h0E}));

        // Level-sensitive capture follows a toggling result every cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus((i % 2) ? 16'hFFFE : 16'h0001, (i % 2) ? 5'b10000 : 5'b00011, 1'b1, 1'b0);
            stepCycle("toggle");
            check("toggle_led", 32'(dispIf.led), 32'((i % 2) ? 5'b10000 : 5'b00011));
        end
        applyStimulus(16'h0, 5'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) stepCycle("toggle_drain");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
